// File: rtl/addr_map_cfg_ctrl_if.sv
// addr_map_cfg_ctrl_if: rule-write and commit handshake between a configuration master and addr_map_cfg_ctrl.
interface addr_map_cfg_ctrl_if #(
    parameter int unsigned SelWidth = 32'd1,
    parameter type rule_t = logic
);
    logic cfg_req_i;
    logic cfg_gnt_o;
    logic [SelWidth-1:0] cfg_sel_i;
    rule_t cfg_rule_i;
    logic cfg_sel_err_o;
    logic commit_i;
    logic commit_done_o;
    logic commit_err_o;
    modport master (
        output cfg_req_i, cfg_sel_i, cfg_rule_i, commit_i,
        input cfg_gnt_o, cfg_sel_err_o, commit_done_o, commit_err_o
    );
    modport slave (
        input cfg_req_i, cfg_sel_i, cfg_rule_i, commit_i,
        output cfg_gnt_o, cfg_sel_err_o, commit_done_o, commit_err_o
    );
endinterface

// File: rtl/addr_map_cfg_ctrl.sv
// addr_map_cfg_ctrl: shadow/active address-map banks with a drain-then-swap commit.
// Defining ADDR_MAP_CFG_CHECK_EN adds rule validation at swap time; failing banks are rejected.
module addr_map_cfg_ctrl #(
    parameter int unsigned NoIndices = 32'd1,
    parameter int unsigned NoRules = 32'd1,
    parameter type addr_t = logic,
    parameter type rule_t = logic,
    parameter int unsigned CntWidth = 32'd8,
    parameter int unsigned RuleSelWidth = (NoRules > 32'd1) ? $clog2(NoRules) : 32'd1
) (
    input logic clk_i,
    input logic rst_i,
    addr_map_cfg_ctrl_if.slave cfg,
    input logic txn_start_i,
    input logic txn_end_i,
    output rule_t [NoRules-1:0] addr_map_o,
    output logic config_ongoing_o,
    output logic busy_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;
    state_e state_q, state_d;
    logic [CntWidth-1:0] cnt_q;
    rule_t [NoRules-1:0] shadow_q, active_q;
    logic [RuleSelWidth-1:0] sel;
    logic init_q, wr_en, sel_ok, swap_ok;

    assign sel = cfg.cfg_sel_i;
    assign sel_ok = 32'(sel) < NoRules;
    assign wr_en = cfg.cfg_req_i && state_q == IDLE;
    assign addr_map_o = active_q;

`ifdef ADDR_MAP_CFG_CHECK_EN
    logic rules_ok;
    always_comb begin
        rules_ok = 1'b1;
        for (int i = 0; i < int'(NoRules); i++)
            if (32'(shadow_q[i].idx) >= NoIndices ||
                (addr_t'(shadow_q[i].start_addr) >= addr_t'(shadow_q[i].end_addr) && shadow_q[i].end_addr != '0))
                rules_ok = 1'b0;
    end
    assign swap_ok = state_q == SWAP && rules_ok;
    assign cfg.commit_err_o = cfg.commit_done_o && !rules_ok;
`else
    assign swap_ok = state_q == SWAP;
    assign cfg.commit_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (cfg.commit_i ? DRAIN : IDLE) :
                  (state_q == DRAIN) ? ((cnt_q == '0) ? SWAP : DRAIN) : IDLE;
    end

    // done is masked by reset so an aborted swap never reports completion
    always_comb begin
        cfg.cfg_gnt_o = state_q == IDLE;
        cfg.cfg_sel_err_o = wr_en && !sel_ok;
        cfg.commit_done_o = state_q == SWAP && !rst_i;
        busy_o = state_q != IDLE;
        config_ongoing_o = busy_o || !init_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            active_q <= '0;
            init_q <= 1'b0;
        end else begin
            if (wr_en && sel_ok) shadow_q[sel] <= cfg.cfg_rule_i;
            if (swap_ok) begin
                active_q <= shadow_q;
                init_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else if (txn_start_i && !txn_end_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        else if (txn_end_i && !txn_start_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: tb/tb_addr_map_cfg_ctrl.sv
// tb_addr_map_cfg_ctrl: directed + randomized bench for addr_map_cfg_ctrl against a bank/counter model.
module tb_addr_map_cfg_ctrl;
    typedef logic [15:0] addr_t;
    typedef struct packed {
        logic [3:0] idx;
        addr_t start_addr;
        addr_t end_addr;
    } rule_t;
    localparam int NR = 3, NI = 4, CMAX = 7;

    logic clk = 1'b0, rst = 1'b1, txn_start = 1'b0, txn_end = 1'b0, ongoing, busy;
    rule_t [NR-1:0] map;
    int checks = 0, failures = 0;
    rule_t [NR-1:0] m_shadow, m_active;
    bit m_init;
    int m_cnt;

    addr_map_cfg_ctrl_if #(.SelWidth(2), .rule_t(rule_t)) cfg_if ();

    addr_map_cfg_ctrl #(
        .NoIndices(NI), .NoRules(NR), .addr_t(addr_t), .rule_t(rule_t), .CntWidth(3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_if), .txn_start_i(txn_start), .txn_end_i(txn_end),
        .addr_map_o(map), .config_ongoing_o(ongoing), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rule_ok(input rule_t r);
`ifdef ADDR_MAP_CFG_CHECK_EN
        return r.idx < NI && (r.start_addr < r.end_addr || r.end_addr == 16'h0);
`else
        return r.idx == r.idx;
`endif
    endfunction

    function automatic bit bank_ok();
        bit ok = 1'b1;
        for (int i = 0; i < NR; i++) ok &= rule_ok(m_shadow[i]);
        return ok;
    endfunction

    function automatic rule_t rand_rule();
        rule_t r;
        int s = $urandom_range(0, 16'hfffe);
        r.idx = 4'($urandom_range(0, NI - 1));
        r.start_addr = 16'(s);
        r.end_addr = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(s + 1, 16'hffff));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_shadow = '0;
        m_active = '0;
        m_init = 1'b0;
        m_cnt = 0;
    endtask

    task automatic write(input logic [1:0] sel, input rule_t r);
        cfg_if.cfg_req_i = 1'b1;
        cfg_if.cfg_sel_i = sel;
        cfg_if.cfg_rule_i = r;
        #1;
        chk("gnt_idle", cfg_if.cfg_gnt_o, 1);
        chk("sel_err", cfg_if.cfg_sel_err_o, sel >= NR);
        tick();
        cfg_if.cfg_req_i = 1'b0;
        if (sel < NR) m_shadow[sel] = r;
    endtask

    task automatic txn(input bit s, input bit e);
        txn_start = s;
        txn_end = e;
        tick();
        txn_start = 1'b0;
        txn_end = 1'b0;
        if (s && !e) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        if (e && !s) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
    endtask

    task automatic start_commit();
        cfg_if.commit_i = 1'b1;
        tick();
        cfg_if.commit_i = 1'b0;
        chk("drain_busy", busy, 1);
        chk("drain_ongoing", ongoing, 1);
        chk("drain_gnt", cfg_if.cfg_gnt_o, 0);
        chk("drain_done", cfg_if.commit_done_o, 0);
    endtask

    task automatic drain_hold(input int n);
        repeat (n) begin
            tick();
            chk("hold_busy", busy, 1);
            chk("hold_done", cfg_if.commit_done_o, 0);
            chk("hold_gnt", cfg_if.cfg_gnt_o, 0);
            chk("hold_ongoing", ongoing, 1);
        end
    endtask

    task automatic finish_commit();
        bit ok = bank_ok();
        tick();
        chk("swap_done", cfg_if.commit_done_o, 1);
        chk("swap_err", cfg_if.commit_err_o, !ok);
        chk("swap_map_held", map, m_active);
        if (ok) begin
            m_active = m_shadow;
            m_init = 1'b1;
        end
        tick();
        chk("post_map", map, m_active);
        chk("post_busy", busy, 0);
        chk("post_ongoing", ongoing, !m_init);
        chk("post_done", cfg_if.commit_done_o, 0);
        chk("post_err", cfg_if.commit_err_o, 0);
    endtask

    initial begin
        rule_t r;
        cfg_if.cfg_req_i = 1'b0;
        cfg_if.cfg_sel_i = 2'd0;
        cfg_if.cfg_rule_i = '0;
        cfg_if.commit_i = 1'b0;
        do_reset();
        chk("rst_gnt", cfg_if.cfg_gnt_o, 1);
        chk("rst_ongoing", ongoing, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_if.commit_done_o, 0);
        chk("rst_err", cfg_if.commit_err_o, 0);
        chk("rst_map", map, 0);
        // basic commit with zero in-flight count
        write(2'd0, rule_t'{4'd1, 16'h1000, 16'h2000});
        start_commit();
        finish_commit();
        // random bank contents
        for (int i = 0; i < NR; i++) write(2'(i), rand_rule());
        start_commit();
        finish_commit();
        // drain waits for in-flight transactions; writes and commits during drain are ignored
        repeat (3) txn(1'b1, 1'b0);
        start_commit();
        cfg_if.cfg_req_i = 1'b1;
        cfg_if.cfg_sel_i = 2'd1;
        cfg_if.cfg_rule_i = rand_rule();
        cfg_if.commit_i = 1'b1;
        drain_hold(3);
        cfg_if.cfg_req_i = 1'b0;
        cfg_if.commit_i = 1'b0;
        repeat (3) txn(1'b0, 1'b1);
        finish_commit();
        tick();
        chk("commit_not_queued", busy, 0);
        // write in the commit cycle is included
        r = rand_rule();
        cfg_if.cfg_req_i = 1'b1;
        cfg_if.cfg_sel_i = 2'd2;
        cfg_if.cfg_rule_i = r;
        start_commit();
        cfg_if.cfg_req_i = 1'b0;
        m_shadow[2] = r;
        finish_commit();
        // out-of-range slot is dropped
        write(2'd3, rand_rule());
        start_commit();
        finish_commit();
        // simultaneous start/end leaves count unchanged
        txn(1'b1, 1'b0);
        txn(1'b1, 1'b1);
        start_commit();
        drain_hold(2);
        txn(1'b0, 1'b1);
        finish_commit();
        // counter saturates at max
        repeat (9) txn(1'b1, 1'b0);
        repeat (6) txn(1'b0, 1'b1);
        start_commit();
        drain_hold(2);
        txn(1'b0, 1'b1);
        finish_commit();
        // random traffic then drain
        repeat (20) txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        write(2'($urandom_range(0, 2)), rand_rule());
        start_commit();
        while (m_cnt > 0) begin
            drain_hold(1);
            txn(1'b0, 1'b1);
        end
        finish_commit();
        // inverted range rule from a never-committed state
        do_reset();
        write(2'd0, rule_t'{4'd0, 16'h2000, 16'h1000});
        start_commit();
        finish_commit();
        // reset during swap aborts the commit
        do_reset();
        write(2'd1, rule_t'{4'd2, 16'h3000, 16'h4000});
        start_commit();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_state_swap", busy, 1);
        chk("abort_no_done", cfg_if.commit_done_o, 0);
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_map", map, 0);
        chk("abort_gnt", cfg_if.cfg_gnt_o, 1);
        chk("abort_ongoing", ongoing, 1);
        tick();
        chk("abort_no_late_done", cfg_if.commit_done_o, 0);
        chk("abort_map_late", map, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addr_map_cfg_ctrl.md
ADDR_MAP_CFG_CTRL -- requirements
Module: addr_map_cfg_ctrl

Interface
REQ-001 Parameter NoIndices, default 32'd1: highest legal rule index + 1, checked only when ADDR_MAP_CFG_CHECK_EN is defined.
REQ-002 Parameter NoRules, default 32'd1: number of rules held; SHALL be > 0.
REQ-003 Parameter type addr_t, default logic: address type of start_addr/end_addr.
REQ-004 Parameter type rule_t, default logic: packed struct with fields idx, start_addr, end_addr.
REQ-005 Parameter CntWidth, default 32'd8: in-flight counter width.
REQ-006 Dependent parameter RuleSelWidth = cf_math_pkg::idx_width(NoRules); SHALL not be overridden.
REQ-007 clk_i  in  1  clock; all state updates on the rising edge.
REQ-008 rst_i  in  1  reset; synchronous, active-high.
REQ-009 cfg_req_i  in  1  rule write request.
REQ-010 cfg_gnt_o  out  1  rule write accepted; a write completes in any cycle with cfg_req_i && cfg_gnt_o.
REQ-011 cfg_sel_i  in  RuleSelWidth  shadow-bank rule slot to write.
REQ-012 cfg_rule_i  in  $bits(rule_t)  rule value to write.
REQ-013 cfg_sel_err_o  out  1  one-cycle pulse: accepted write had cfg_sel_i >= NoRules; write dropped.
REQ-014 commit_i  in  1  request to transfer the shadow bank to the active bank.
REQ-015 commit_done_o  out  1  one-cycle pulse: commit finished (successful or rejected).
REQ-016 commit_err_o  out  1  one-cycle pulse concurrent with commit_done_o: shadow bank rejected.
REQ-017 txn_start_i  in  1  one decoded transaction issued downstream.
REQ-018 txn_end_i  in  1  one decoded transaction retired downstream.
REQ-019 addr_map_o  out  NoRules x rule_t  active map; drives the decoder address-map input.
REQ-020 config_ongoing_o  out  1  drives the decoder config-ongoing input.
REQ-021 busy_o  out  1  FSM is not in IDLE.

Function
REQ-022 FSM states: IDLE, DRAIN, SWAP; encoding free.
REQ-023 cfg_gnt_o SHALL equal 1 in IDLE and 0 otherwise; shadow writes occur only in IDLE.
REQ-024 An accepted write with cfg_sel_i < NoRules SHALL update shadow[cfg_sel_i] at that edge; shadow is never read by the decoder.
REQ-025 IDLE with commit_i=1 -> DRAIN next cycle; a write accepted in the same cycle SHALL be included in the commit.
REQ-026 DRAIN -> SWAP when the in-flight count is 0; otherwise DRAIN holds, with no timeout.
REQ-027 SWAP lasts exactly one cycle: commit_done_o=1; on success, active <= shadow at the closing edge; next state IDLE.
REQ-028 config_ongoing_o = (state != IDLE) || !init_q, where init_q is set by the first successful commit.
REQ-029 Latency with count=0: commit_i sampled at cycle N -> DRAIN at N+1 -> SWAP at N+2 -> new addr_map_o and IDLE at N+3.
REQ-030 commit_i outside IDLE SHALL be ignored, not queued.
REQ-031 In-flight count, CntWidth bits: +1 on txn_start_i only; -1 on txn_end_i only; unchanged when both are asserted.
REQ-032 The count SHALL saturate at all-ones on increment and hold at 0 on decrement.
REQ-033 The count SHALL update in all states.
REQ-034 addr_map_o SHALL change only at the closing edge of a successful SWAP.

Reset
REQ-035 On rst_i=1 at a clock edge: state IDLE; active and shadow banks all-zero; count 0; init_q 0.
REQ-036 Resulting outputs: cfg_gnt_o=1, config_ongoing_o=1, busy_o=0, all pulses 0, addr_map_o all-zero.
REQ-037 Reset mid-DRAIN or mid-SWAP SHALL abort the commit with no commit_done_o and no active-bank update.

Configuration
REQ-038 With ADDR_MAP_CFG_CHECK_EN defined, SWAP SHALL validate every shadow rule: idx < NoIndices and (start_addr < end_addr or end_addr == '0).
REQ-039 With ADDR_MAP_CFG_CHECK_EN defined, any failing rule SHALL set commit_err_o=1, leave the active bank and init_q unchanged, and still return to IDLE.
REQ-040 Without ADDR_MAP_CFG_CHECK_EN, no check logic SHALL exist, commit_err_o SHALL be tied to 0, and every commit succeeds.

Verification
REQ-041 Reset; write slot 0 {idx 1, 0x1000, 0x2000}; commit with count 0 -> commit_done_o at N+2; addr_map_o[0] updated and config_ongoing_o=0 at N+3.
REQ-042 Three txn_start_i, then commit -> DRAIN holds with config_ongoing_o=1; after 3 txn_end_i -> SWAP in the following cycle.
REQ-043 cfg_req_i held during DRAIN -> cfg_gnt_o=0 and shadow unchanged; write plus commit_i in the same IDLE cycle -> write included in the commit.
REQ-044 cfg_sel_i=NoRules -> cfg_sel_err_o pulse and no slot changed; txn_start_i and txn_end_i together -> count unchanged; increment at max -> count stays max.
REQ-045 With the macro defined: rule {0x2000, 0x1000} -> commit_err_o=1, addr_map_o unchanged, config_ongoing_o=1 if never committed; without the macro, the same rule is committed.
REQ-046 rst_i asserted in SWAP -> no commit_done_o, addr_map_o all-zero, state IDLE.
